// File: rtl/ysyx_24110015_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_ifu_fetch
//
// Purpose
//   Instruction fetch unit for a multicycle core. It holds the PC and issues
//   one read per instruction on a valid/ready memory read channel. It then
//   presents the fetched word and its PC to decode with a valid/ready
//   handshake. The next fetch starts only after writeback supplies the
//   next PC.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   npc, npc_valid           next PC from writeback (single-cycle pulse)
//   araddr, arvalid, arready read address channel (araddr is the pc register)
//   rdata, rresp, rvalid,    read data channel (rresp 2'b00 = OKAY)
//   rready
//   inst, pc, fault,         fetched instruction, its PC and fault flag,
//   out_valid, out_ready     handed to decode
//
// Configuration macro
//   IFU_FAULT_EN  When defined, the unit does not issue a misaligned PC on
//                 the bus. That fetch, and any read with rresp != OKAY,
//                 produces fault=1 and inst=FAULT_INST. When undefined,
//                 fault is constant 0, rresp is ignored and a misaligned PC
//                 is issued on araddr unchanged.
// ---------------------------------------------------------------------------
module ysyx_24110015_ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_nxt;

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;

  logic        misalign;
  logic        resp_fault;

  logic        pc_load;
  logic        rd_capture;
  logic        skip_capture;

`ifdef IFU_FAULT_EN
  assign misalign   = |pc_q[1:0];
  assign resp_fault = |rresp;
`else
  logic rresp_unused;
  assign rresp_unused = |rresp;
  assign misalign     = 1'b0;
  assign resp_fault   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt    = state_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    out_valid    = 1'b0;
    pc_load      = 1'b0;
    rd_capture   = 1'b0;
    skip_capture = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_nxt = S_REQ;
      end

      S_REQ: begin
        // A misaligned PC never reaches the bus. It goes straight to OUT
        // carrying a fault.
        if (misalign) begin
          skip_capture = 1'b1;
          state_nxt    = S_OUT;
        end else begin
          arvalid = 1'b1;
          if (arready) begin
            state_nxt = S_RESP;
          end
        end
      end

      S_RESP: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_capture = 1'b1;
          state_nxt  = S_OUT;
        end
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Writeback may deliver npc in the very cycle decode consumes the
          // instruction. In that case, skip WAIT and fetch right away.
          if (npc_valid) begin
            pc_load   = 1'b1;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (npc_valid) begin
          pc_load   = 1'b1;
          state_nxt = S_REQ;
        end
      end

      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // PC register: changes only on an accepted npc. An npc pulse in any
  // other state is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (pc_load) begin
      pc_q <= npc;
    end
  end

  // Instruction/fault capture: held stable through OUT until the next
  // capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else if (skip_capture) begin
      inst_q  <= FAULT_INST;
      fault_q <= 1'b1;
    end else if (rd_capture) begin
      inst_q  <= resp_fault ? FAULT_INST : rdata;
      fault_q <= resp_fault;
    end
  end

  assign araddr = pc_q;
  assign pc     = pc_q;
  assign inst   = inst_q;
  assign fault  = fault_q;

endmodule
